mem_console_uart: RTL and testbench

MEM_CONSOLE_UART -- requirements
Module: mem_console_uart

---
 rtl/mem_console_pkg.sv | 30 +++
 rtl/mem_console_uart_fifo.sv | 52 +++++
 rtl/mem_console_uart.sv | 159 +++++++++++++++
 tb/tb_mem_console_uart.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_console_pkg.sv
// Shared definitions for the memory-mapped console UART: register offsets,
// STATUS bit positions and the transmitter state encoding.
package mem_console_pkg;

    localparam logic [2:0] OFS_DATA   = 3'h0;
    localparam logic [2:0] OFS_STATUS = 3'h4;

    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    // Expands a 4-bit byte mask into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] mask);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = {8{mask[i]}};
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_console_uart_fifo.sv
// Single-clock byte FIFO feeding the console transmitter; reports full,
// empty and occupancy. Callers never push while full or pop while empty.
module console_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mem_console_uart.sv
// Memory-mapped console UART: DATA/STATUS register window on a valid/ready
// bus, byte TX FIFO, and an 8N1 serial transmitter with a registered line.
module mem_console_uart
    import mem_console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic [3:0]  mem_rmask,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          sel;
    logic          is_data;
    logic          is_status;
    logic          is_write;
    logic          byte_write;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status_word;

    tx_state_e     state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          div_done;

    logic unused_bits;
    assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0]};

    // Bus decode; a full FIFO stalls only byte-0 DATA writes.
    assign sel        = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign is_data    = (mem_addr[2] == OFS_DATA[2]);
    assign is_status  = (mem_addr[2] == OFS_STATUS[2]);
    assign is_write   = |mem_wstrb;
    assign byte_write = sel && is_data && mem_wstrb[0];
    assign mem_ready  = sel && !(byte_write && fifo_full);
    assign push       = byte_write && !fifo_full;
    assign tx_busy    = !fifo_empty || (state != S_IDLE);

    always_comb begin
        status_word                           = '0;
        status_word[ST_BUSY_BIT]              = tx_busy;
        status_word[ST_FULL_BIT]              = fifo_full;
        status_word[ST_EMPTY_BIT]             = fifo_empty;
        status_word[ST_COUNT_LSB +: 8]        = 8'(fifo_count);
    end

    assign mem_rdata = (sel && is_status && !is_write)
                     ? (status_word & byte_mask(mem_rmask)) : '0;

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (mem_wdata[7:0]),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign div_done = (div_cnt == DIV_LAST);

    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_n = state;
        div_n   = div_cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift;
        pop     = 1'b0;
        tx_n    = 1'b1;
        case (state)
            S_IDLE: begin
                div_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_rdata;
                    bit_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                tx_n = 1'b0;
                if (div_done) begin
                    div_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                tx_n = shift[0];
                if (div_done) begin
                    div_n   = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) state_n = S_STOP;
                    else                 bit_n   = bit_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (div_done) begin
                    div_n = '0;
                    // Chain straight into the next frame when bytes are waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_rdata;
                        bit_n   = '0;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state and the line register use non-blocking assignments so all
    // of them update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            uart_tx <= tx_n;
        end
    end

endmodule

// File: tb/tb_mem_console_uart.sv
// Self-checking bench for mem_console_uart: a timeline/queue model predicts
// the bus responses and serial line every cycle, plus directed literal checks.
module tb_mem_console_uart;

    localparam int          DIV   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * DIV;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [3:0]  mem_rmask;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_busy;

    mem_console_uart #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rmask (mem_rmask),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // q holds bytes waiting in the FIFO; m counts edges since the current
    // frame's byte was taken (-1 when no frame is being sent).
    logic [7:0] q[$];
    int         m          = -1;
    logic [7:0] frame_byte = 8'h00;
    logic       line_exp   = 1'b1;
    bit         model_on   = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int seg);
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
        return 1'b1;
    endfunction

    function automatic logic model_busy();
        return (m >= 0) || (q.size() > 0);
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = model_busy();
        s[1]     = (q.size() == DEPTH);
        s[2]     = (q.size() == 0);
        s[15:8]  = 8'(q.size());
        return s;
    endfunction

    function automatic logic model_ready();
        logic sel;
        sel = mem_valid && (mem_addr[31:3] == BASE[31:3]);
        return sel && !(!mem_addr[2] && mem_wstrb[0] && (q.size() == DEPTH));
    endfunction

    function automatic logic [31:0] model_rdata();
        logic [31:0] mask;
        if (!(mem_valid && (mem_addr[31:3] == BASE[31:3]) && mem_addr[2] && (mem_wstrb == 4'h0)))
            return 32'h0;
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{mem_rmask[i]}};
        return model_status() & mask;
    endfunction

    task automatic model_step();
        bit         do_pop;
        bit         do_push;
        logic [7:0] wbyte;
        if (!resetn) begin
            q.delete();
            m        = -1;
            line_exp = 1'b1;
            model_on = 1'b1;
        end else if (model_on) begin
            do_pop   = (q.size() > 0) && ((m < 0) || (m == FRAME - 1));
            do_push  = model_ready() && !mem_addr[2] && mem_wstrb[0];
            wbyte    = mem_wdata[7:0];
            line_exp = (m >= 0) ? frame_bit(frame_byte, m / DIV) : 1'b1;
            if (do_pop) begin
                frame_byte = q.pop_front();
                m          = 0;
            end else if (m >= 0) begin
                m++;
                if (m == FRAME) m = -1;
            end
            if (do_push) q.push_back(wbyte);
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare ----------------
    int busy_run     = 0;
    int busy_run_max = 0;

    always @(negedge clk) begin
        if (model_on) begin
            check("uart_tx",   uart_tx,   line_exp);
            check("tx_busy",   tx_busy,   model_busy());
            check("mem_ready", mem_ready, model_ready());
            check("mem_rdata", mem_rdata, model_rdata());
        end
        if (tx_busy === 1'b1) begin
            busy_run++;
            if (busy_run > busy_run_max) busy_run_max = busy_run;
        end else begin
            busy_run = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_bus();
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        mem_rmask = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output int stalls);
        bit r;
        bit done;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        mem_wstrb = strb;
        mem_rmask = 4'h0;
        stalls    = 0;
        done      = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            r = mem_ready;
            @(posedge clk);
            #1;
            if (r) done = 1'b1;
            else   stalls++;
        end
        idle_bus();
        if (!done) check("write_handshake_timeout", 32'(done), 32'h1);
    endtask

    task automatic read_reg(input logic [31:0] addr, input logic [3:0] rmask,
                            output logic [31:0] data);
        bit done;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = '0;
        mem_wstrb = 4'h0;
        mem_rmask = rmask;
        data      = 'x;
        done      = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                data = mem_rdata;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        idle_bus();
        if (!done) check("read_handshake_timeout", 32'(done), 32'h1);
    endtask

    // Drives one cycle regardless of mem_ready and reports what was seen.
    task automatic poke(input logic valid, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] rmask,
                        output logic rdy, output logic [31:0] rd);
        mem_valid = valid;
        mem_addr  = addr;
        mem_wdata = data;
        mem_wstrb = strb;
        mem_rmask = rmask;
        @(negedge clk);
        rdy = mem_ready;
        rd  = mem_rdata;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) done = 1'b1;
        end
        check("drain_timeout", 32'(done), 32'h1);
        cycles(2);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          st;
        int          stall_total;
        logic [31:0] d;
        logic        rdy;
        logic [9:0]  ef;

        idle_bus();
        resetn = 1'b0;
        cycles(3);
        resetn = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        @(posedge clk);
        #1;
        read_reg(BASE + 32'h4, 4'hF, d);
        check("rst_status", d, 32'h0000_0004);

        // Single byte 0x41 from idle: line low two edges after the push edge
        write_reg(BASE, 32'h0000_0041, 4'h1, st);
        check("first_write_no_stall", 32'(st), 32'h0);
        @(negedge clk);
        check("tx_after_push_edge", uart_tx, 1'b1);
        @(negedge clk);
        check("tx_one_edge_later", uart_tx, 1'b1);
        ef = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            check("frame_0x41", uart_tx, ef[k / DIV]);
        end
        check("busy_after_frame", tx_busy, 1'b0);
        @(posedge clk);
        #1;
        wait_idle();

        // Three bytes queued behind a frame in flight
        write_reg(BASE, 32'h55, 4'h1, st);
        write_reg(BASE, 32'h11, 4'h1, st);
        write_reg(BASE, 32'h22, 4'h1, st);
        write_reg(BASE, 32'h33, 4'h1, st);
        read_reg(BASE + 32'h4, 4'hF, d);
        check("status_three_queued", d, 32'h0000_0301);
        read_reg(BASE + 32'h4, 4'h1, d);
        check("status_rmask_byte0", d, 32'h0000_0001);
        wait_idle();

        // Six back-to-back writes: overflow stalls, frames chain without gaps
        busy_run_max = 0;
        stall_total  = 0;
        for (int i = 0; i < 6; i++) begin
            write_reg(BASE, 32'($urandom_range(0, 255)), 4'h1, st);
            stall_total += st;
        end
        check("overflow_stalled", 32'(stall_total > 0), 32'h1);
        wait_idle();
        check("gapless_busy_cycles", 32'(busy_run_max), 32'(6 * FRAME + 1));

        // Out-of-window and invalid accesses are ignored
        poke(1'b1, BASE + 32'h8, 32'hA5, 4'h1, 4'h0, rdy, d);
        check("oow_ready", rdy, 1'b0);
        check("oow_rdata", d, 32'h0);
        poke(1'b1, BASE + 32'h8, 32'h0, 4'h0, 4'hF, rdy, d);
        check("oow_read_rdata", d, 32'h0);
        poke(1'b0, BASE, 32'h5A, 4'h1, 4'h0, rdy, d);
        check("novalid_ready", rdy, 1'b0);
        read_reg(BASE + 32'h4, 4'hF, d);
        check("no_push_status", d, 32'h0000_0004);

        // DATA write without byte 0 is acknowledged but not queued
        write_reg(BASE, 32'h77, 4'b0010, st);
        check("wstrb_hi_no_stall", 32'(st), 32'h0);
        read_reg(BASE, 4'hF, d);
        check("data_read_zero", d, 32'h0);
        read_reg(BASE + 32'h4, 4'hF, d);
        check("wstrb_hi_status", d, 32'h0000_0004);

        // Reset in the middle of the data bits with two bytes still queued
        write_reg(BASE, 32'hC3, 4'h1, st);
        write_reg(BASE, 32'h3C, 4'h1, st);
        write_reg(BASE, 32'h99, 4'h1, st);
        cycles(7);
        read_reg(BASE + 32'h4, 4'hF, d);
        check("pre_reset_status", d, 32'h0000_0201);
        resetn = 1'b0;
        cycles(1);
        resetn = 1'b1;
        @(negedge clk);
        check("mid_reset_tx", uart_tx, 1'b1);
        @(posedge clk);
        #1;
        read_reg(BASE + 32'h4, 4'hF, d);
        check("mid_reset_status", d, 32'h0000_0004);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] addr;
            logic [3:0]  strb;
            int          pick;
            pick = $urandom_range(0, 9);
            if (pick < 5)      addr = BASE;
            else if (pick < 8) addr = BASE + 32'h4;
            else if (pick < 9) addr = BASE + 32'h8 + 32'($urandom_range(0, 3) * 4);
            else               addr = $urandom;
            strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 299) == 0) begin
                resetn = 1'b0;
                cycles(1);
                resetn = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                cycles($urandom_range(1, 12));
            end else begin
                poke(($urandom_range(0, 7) != 0), addr, $urandom, strb,
                     4'($urandom_range(0, 15)), rdy, d);
            end
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
